// File: rtl/sd_host_pkg.sv
// Shared types and constants for the SD host command path.
package sd_host_pkg;

  typedef enum logic [1:0] {
    RESP_NONE = 2'b00,
    RESP_136  = 2'b01,
    RESP_48   = 2'b10,
    RESP_48B  = 2'b11
  } resp_type_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT_RESP,
    ST_RECV,
    ST_CHECK,
    ST_DONE
  } state_e;

  // Command register (00Eh) image
  typedef struct packed {
    logic [1:0] rsvd_hi;
    logic [5:0] index;
    logic [2:0] rsvd_mid;
    logic       idx_chk;
    logic       crc_chk;
    logic       rsvd_lo;
    resp_type_e resp_type;
  } cmd_reg_t;

  localparam int unsigned FRAME_LEN_48  = 48;
  localparam int unsigned FRAME_LEN_136 = 136;
  localparam int unsigned CRC_COVER_48  = 40;
  localparam int unsigned CRC7_W        = 7;
  localparam logic [CRC7_W-1:0] CRC7_POLY = 7'h09;

endpackage

// File: rtl/sd_cmd_issuer_if.sv
// Register-block / CMD-line bundle for the SD command engine.
interface sd_cmd_issuer_if;
  logic [31:0]  cmd_arg;
  logic [15:0]  cmd_reg;
  logic         cmd_wr_en;
  logic         sd_cmd_in;
  logic         sd_cmd_out;
  logic         sd_cmd_oe;
  logic [127:0] resp;
  logic         cmd_inhibit;
  logic         cmd_complete;
  logic         timeout_err;
  logic         crc_err;
  logic         index_err;
  logic         end_bit_err;

  modport master (
    output cmd_arg, cmd_reg, cmd_wr_en, sd_cmd_in,
    input  sd_cmd_out, sd_cmd_oe, resp, cmd_inhibit,
    input  cmd_complete, timeout_err, crc_err, index_err, end_bit_err
  );

  modport slave (
    input  cmd_arg, cmd_reg, cmd_wr_en, sd_cmd_in,
    output sd_cmd_out, sd_cmd_oe, resp, cmd_inhibit,
    output cmd_complete, timeout_err, crc_err, index_err, end_bit_err
  );
endinterface

// File: rtl/sd_crc7.sv
// Serial CRC7 (x^7+x^3+1), one bit per enabled clock, cleared to zero.
module sd_crc7
  import sd_host_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              en,
  input  logic              bit_in,
  output logic [CRC7_W-1:0] crc
);

  logic fb;

  assign fb = bit_in ^ crc[CRC7_W-1];

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      crc <= '0;
    end else if (en) begin
      crc <= {crc[CRC7_W-2:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
    end
  end

endmodule

// File: rtl/sd_cmd_issuer.sv
// SD CMD-line engine: sends a 48-bit command, receives and checks the response.
// Optional receive CRC checking is built when SD_CMD_CRC_CHECK_EN is defined.
module sd_cmd_issuer
  import sd_host_pkg::*;
#(
  parameter int unsigned RESP_TIMEOUT = 64
) (
  input logic            clk,
  input logic            reset,
  sd_cmd_issuer_if.slave bus
);

  localparam int unsigned TO_W  = $clog2(RESP_TIMEOUT + 1);
  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] LAST_48       = CNT_W'(FRAME_LEN_48 - 1);
  localparam logic [CNT_W-1:0] LAST_136      = CNT_W'(FRAME_LEN_136 - 1);
  localparam logic [CNT_W-1:0] CRC_END_48    = CNT_W'(CRC_COVER_48);
  localparam logic [CNT_W-1:0] CRC_START_136 = CNT_W'(8);
  localparam logic [CNT_W-1:0] CRC_END_136   = CNT_W'(FRAME_LEN_136 - 8);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
  logic [38:0]        tx_sr_q, tx_sr_d;
  logic [126:0]       rx_sr_q, rx_sr_d;
  logic [5:0]         idx_q, idx_d;
  resp_type_e         type_q, type_d;
  logic               idx_chk_q, idx_chk_d;
  logic               crc_chk_q, crc_chk_d;
  logic               end_bad_q, end_bad_d;
  logic               cmd_out_q, cmd_out_d;
  logic               oe_q, oe_d;
  logic               inhibit_q, inhibit_d;
  logic [127:0]       resp_q, resp_d;
  logic               complete_q, complete_d;
  logic               timeout_q, timeout_d;
  logic               crc_err_q, crc_err_d;
  logic               index_err_q, index_err_d;
  logic               end_err_q, end_err_d;

  cmd_reg_t           creg;
  logic               is_136_c;
  logic               crc_bad_c;
  logic [CRC7_W-1:0]  tx_crc;
  logic               tx_crc_clr, tx_crc_en, tx_crc_bit;
  logic               rx_crc_clr, rx_crc_en;
  logic               unused_creg;

  assign creg        = cmd_reg_t'(bus.cmd_reg);
  assign is_136_c    = (type_q == RESP_136);
  assign unused_creg = ^{creg.rsvd_hi, creg.rsvd_mid, creg.rsvd_lo};

  // Clearing at accept equals having absorbed the start bit (0 into a zero CRC).
  sd_crc7 u_tx_crc (
    .clk    (clk),
    .reset  (reset),
    .clear  (tx_crc_clr),
    .en     (tx_crc_en),
    .bit_in (tx_crc_bit),
    .crc    (tx_crc)
  );

`ifdef SD_CMD_CRC_CHECK_EN
  logic [CRC7_W-1:0] rx_crc;

  sd_crc7 u_rx_crc (
    .clk    (clk),
    .reset  (reset),
    .clear  (rx_crc_clr),
    .en     (rx_crc_en),
    .bit_in (bus.sd_cmd_in),
    .crc    (rx_crc)
  );

  assign crc_bad_c = crc_chk_q && (rx_crc != rx_sr_q[CRC7_W-1:0]);
`else
  logic unused_rx_crc;

  assign crc_bad_c     = 1'b0;
  assign unused_rx_crc = ^{rx_crc_clr, rx_crc_en, crc_chk_q};
`endif

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    to_cnt_d    = to_cnt_q;
    tx_sr_d     = tx_sr_q;
    rx_sr_d     = rx_sr_q;
    idx_d       = idx_q;
    type_d      = type_q;
    idx_chk_d   = idx_chk_q;
    crc_chk_d   = crc_chk_q;
    end_bad_d   = end_bad_q;
    cmd_out_d   = cmd_out_q;
    oe_d        = oe_q;
    inhibit_d   = inhibit_q;
    resp_d      = resp_q;
    complete_d  = 1'b0;
    timeout_d   = 1'b0;
    crc_err_d   = 1'b0;
    index_err_d = 1'b0;
    end_err_d   = 1'b0;
    tx_crc_clr  = 1'b0;
    tx_crc_en   = 1'b0;
    tx_crc_bit  = 1'b0;
    rx_crc_clr  = 1'b0;
    rx_crc_en   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.cmd_wr_en) begin
          state_d    = ST_SEND;
          idx_d      = creg.index;
          type_d     = creg.resp_type;
          idx_chk_d  = creg.idx_chk;
          crc_chk_d  = creg.crc_chk;
          tx_sr_d    = {1'b1, creg.index, bus.cmd_arg};
          cmd_out_d  = 1'b0;
          oe_d       = 1'b1;
          inhibit_d  = 1'b1;
          bit_cnt_d  = '0;
          tx_crc_clr = 1'b1;
          rx_crc_clr = 1'b1;
        end
      end

      ST_SEND: begin
        if (bit_cnt_q == LAST_48) begin
          oe_d      = 1'b0;
          cmd_out_d = 1'b1;
          to_cnt_d  = '0;
          if (type_q == RESP_NONE) begin
            state_d    = ST_DONE;
            complete_d = 1'b1;
            inhibit_d  = 1'b0;
          end else begin
            state_d = ST_WAIT_RESP;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q < CRC_END_48 - 1'b1) begin
            cmd_out_d  = tx_sr_q[38];
            tx_sr_d    = {tx_sr_q[37:0], 1'b0};
            tx_crc_en  = 1'b1;
            tx_crc_bit = tx_sr_q[38];
          end else if (bit_cnt_q < LAST_48 - 1'b1) begin
            cmd_out_d = tx_crc[3'(LAST_48 - 8'd2 - bit_cnt_q)];
          end else begin
            cmd_out_d = 1'b1;
          end
        end
      end

      ST_WAIT_RESP: begin
        if (!bus.sd_cmd_in) begin
          state_d   = ST_RECV;
          bit_cnt_d = CNT_W'(1);
          rx_sr_d   = {rx_sr_q[125:0], 1'b0};
          rx_crc_en = !is_136_c;
        end else if (to_cnt_q == TO_W'(RESP_TIMEOUT - 1)) begin
          state_d   = ST_DONE;
          timeout_d = 1'b1;
          inhibit_d = 1'b0;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end

      ST_RECV: begin
        if (bit_cnt_q == (is_136_c ? LAST_136 : LAST_48)) begin
          end_bad_d = !bus.sd_cmd_in;
          state_d   = ST_CHECK;
        end else begin
          rx_sr_d   = {rx_sr_q[125:0], bus.sd_cmd_in};
          bit_cnt_d = bit_cnt_q + 1'b1;
          rx_crc_en = is_136_c ? (bit_cnt_q >= CRC_START_136 && bit_cnt_q < CRC_END_136)
                               : (bit_cnt_q < CRC_END_48);
        end
      end

      // rx_sr holds every bit but the end bit; the CRC field sits in [6:0]
      ST_CHECK: begin
        state_d    = ST_DONE;
        complete_d = 1'b1;
        inhibit_d  = 1'b0;
        end_err_d  = end_bad_q;
        crc_err_d  = crc_bad_c;
        if (is_136_c) begin
          resp_d = {8'h00, rx_sr_q[126:7]};
        end else begin
          resp_d      = {resp_q[127:32], rx_sr_q[38:7]};
          index_err_d = idx_chk_q && (rx_sr_q[44:39] != idx_q);
        end
      end

      ST_DONE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      to_cnt_q    <= '0;
      tx_sr_q     <= '0;
      rx_sr_q     <= '0;
      idx_q       <= '0;
      type_q      <= RESP_NONE;
      idx_chk_q   <= 1'b0;
      crc_chk_q   <= 1'b0;
      end_bad_q   <= 1'b0;
      cmd_out_q   <= 1'b1;
      oe_q        <= 1'b0;
      inhibit_q   <= 1'b0;
      resp_q      <= '0;
      complete_q  <= 1'b0;
      timeout_q   <= 1'b0;
      crc_err_q   <= 1'b0;
      index_err_q <= 1'b0;
      end_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      to_cnt_q    <= to_cnt_d;
      tx_sr_q     <= tx_sr_d;
      rx_sr_q     <= rx_sr_d;
      idx_q       <= idx_d;
      type_q      <= type_d;
      idx_chk_q   <= idx_chk_d;
      crc_chk_q   <= crc_chk_d;
      end_bad_q   <= end_bad_d;
      cmd_out_q   <= cmd_out_d;
      oe_q        <= oe_d;
      inhibit_q   <= inhibit_d;
      resp_q      <= resp_d;
      complete_q  <= complete_d;
      timeout_q   <= timeout_d;
      crc_err_q   <= crc_err_d;
      index_err_q <= index_err_d;
      end_err_q   <= end_err_d;
    end
  end

  assign bus.sd_cmd_out   = cmd_out_q;
  assign bus.sd_cmd_oe    = oe_q;
  assign bus.cmd_inhibit  = inhibit_q;
  assign bus.resp         = resp_q;
  assign bus.cmd_complete = complete_q;
  assign bus.timeout_err  = timeout_q;
  assign bus.crc_err      = crc_err_q;
  assign bus.index_err    = index_err_q;
  assign bus.end_bit_err  = end_err_q;

endmodule

// File: tb/tb_sd_cmd_issuer.sv
// Directed bench for sd_cmd_issuer: frames, responses, error pulses, timeout, reset.
module tb_sd_cmd_issuer;

  logic clk = 1'b0;
  logic reset;
  int   n_chk = 0;
  int   n_bad = 0;
  bit   ab;

  sd_cmd_issuer_if bus ();

  sd_cmd_issuer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // status order: {complete, timeout, crc, index, end}
  logic [4:0] st;
  assign st = {bus.cmd_complete, bus.timeout_err, bus.crc_err, bus.index_err, bus.end_bit_err};

`ifdef SD_CMD_CRC_CHECK_EN
  localparam logic [4:0] ST_CRC_ON = 5'b10100;
`else
  localparam logic [4:0] ST_CRC_ON = 5'b10000;
`endif

  localparam logic [47:0]  TX_CMD8 = 48'h48_0000_01AA_87;
  localparam logic [119:0] CID     = 120'h035344534431364780123456780123;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] crc7_calc(input logic [127:0] data, input int n);
    logic [6:0] c;
    logic       fb;
    c = '0;
    for (int i = n - 1; i >= 0; i--) begin
      fb = data[i] ^ c[6];
      c  = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    return c;
  endfunction

  // Issue a command and capture the 48 transmitted bits; returns in cycle N+49.
  task automatic send_cmd(input logic [15:0] creg, input logic [31:0] arg,
                          input logic [47:0] exp_tx, input int glitch_at,
                          input int rst_at, output bit aborted);
    logic [47:0] got;
    bit          oe_all;
    aborted = 1'b0;
    got     = '0;
    oe_all  = 1'b1;
    @(negedge clk);
    bus.cmd_reg   = creg;
    bus.cmd_arg   = arg;
    bus.cmd_wr_en = 1'b1;
    @(negedge clk);
    bus.cmd_wr_en = 1'b0;
    check("inhibit_on", 128'(bus.cmd_inhibit), 128'd1);
    for (int i = 0; i < 48; i++) begin
      if (i > 0) @(negedge clk);
      if (i == glitch_at) begin
        bus.cmd_wr_en = 1'b1;
        bus.cmd_arg   = 32'hFFFF_FFFF;
        bus.cmd_reg   = 16'h3F1A;
      end
      if (i == glitch_at + 1) bus.cmd_wr_en = 1'b0;
      if (i == rst_at) begin
        reset = 1'b1;
        @(negedge clk);
        check("rst_oe_out", 128'({bus.sd_cmd_oe, bus.sd_cmd_out}), 128'd1);
        check("rst_inhibit", 128'(bus.cmd_inhibit), 128'd0);
        check("rst_resp", bus.resp, 128'd0);
        check("rst_pulses", 128'(st), 128'd0);
        reset   = 1'b0;
        aborted = 1'b1;
        return;
      end
      got    = {got[46:0], bus.sd_cmd_out};
      oe_all = oe_all & bus.sd_cmd_oe;
    end
    check("tx_frame", 128'(got), 128'(exp_tx));
    check("tx_oe", 128'(oe_all), 128'd1);
    @(negedge clk);
    check("oe_off", 128'({bus.sd_cmd_oe, bus.sd_cmd_out}), 128'd1);
  endtask

  // Drive a response MSB first after 'delay' idle cycles.
  task automatic drive_resp(input logic [135:0] frame, input int nbits, input int delay);
    repeat (delay) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      if (i > 0) @(negedge clk);
      bus.sd_cmd_in = frame[nbits - 1 - i];
    end
  endtask

  // Wait for the DONE cycle and check its latency, pulses and resp.
  task automatic wait_done(input int exp_lat, input logic [4:0] exp_st,
                           input logic [127:0] exp_resp, input bit wr_in_done);
    int n;
    n = 0;
    while (!(bus.cmd_complete || bus.timeout_err) && n < 300) begin
      @(negedge clk);
      bus.sd_cmd_in = 1'b1;
      n++;
    end
    check("latency", 128'(n), 128'(exp_lat));
    check("status", 128'(st), 128'(exp_st));
    check("resp", bus.resp, exp_resp);
    check("inhibit_off", 128'(bus.cmd_inhibit), 128'd0);
    if (wr_in_done) bus.cmd_wr_en = 1'b1;
    @(negedge clk);
    bus.cmd_wr_en = 1'b0;
    bus.sd_cmd_in = 1'b1;
    check("post_done", 128'({bus.sd_cmd_oe, bus.cmd_inhibit, st}), 128'd0);
  endtask

  initial begin
    logic [47:0]  tx_cmd2;
    logic [135:0] r2;
    logic [127:0] resp_exp;

    reset         = 1'b1;
    bus.cmd_arg   = '0;
    bus.cmd_reg   = '0;
    bus.cmd_wr_en = 1'b0;
    bus.sd_cmd_in = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_line", 128'({bus.sd_cmd_oe, bus.sd_cmd_out}), 128'd1);
    check("reset_resp", bus.resp, 128'd0);
    check("reset_flags", 128'({bus.cmd_inhibit, st}), 128'd0);
    reset = 1'b0;

    // CMD0, no response; a write in the DONE cycle must be ignored
    send_cmd(16'h0000, 32'h0, 48'h40_0000_0000_95, -1, -1, ab);
    wait_done(0, 5'b10000, 128'd0, 1'b1);

    // CMD8 with checks; write and arg/reg changes mid-frame must not disturb it
    send_cmd(16'h081A, 32'h0000_01AA, TX_CMD8, 10, -1, ab);
    drive_resp({88'h0, 48'h08_0000_01AA_13}, 48, 2);
    wait_done(2, 5'b10000, 128'h1AA, 1'b0);

    // No response: timeout 64 cycles after oe drops, resp untouched
    send_cmd(16'h081A, 32'h0000_01AA, TX_CMD8, -1, -1, ab);
    wait_done(64, 5'b01000, 128'h1AA, 1'b0);

    // CRC field bit flipped, CRC check enabled then disabled
    send_cmd(16'h081A, 32'h0000_01AA, TX_CMD8, -1, -1, ab);
    drive_resp({88'h0, 48'h08_0000_01AA_11}, 48, 0);
    wait_done(2, ST_CRC_ON, 128'h1AA, 1'b0);

    send_cmd(16'h0812, 32'h0000_01AA, TX_CMD8, -1, -1, ab);
    drive_resp({88'h0, 48'h08_0000_01AA_11}, 48, 5);
    wait_done(2, 5'b10000, 128'h1AA, 1'b0);

    // Wrong index returned with index check on; new content lands in resp
    send_cmd(16'h0812, 32'h0000_01AA, TX_CMD8, -1, -1, ab);
    drive_resp({88'h0, 48'h09_1234_5678_13}, 48, 1);
    wait_done(2, 5'b10010, 128'h1234_5678, 1'b0);

    // End bit low on a 48-bit-busy response with a valid CRC
    send_cmd(16'h081B, 32'h0000_01AA, TX_CMD8, -1, -1, ab);
    drive_resp({88'h0, 48'h08_0000_01AA_12}, 48, 3);
    wait_done(2, 5'b10001, 128'h1AA, 1'b0);

    // CMD2, 136-bit CID response; index field 111111 is not index-checked
    tx_cmd2 = {40'h42_0000_0000, crc7_calc({88'h0, 40'h42_0000_0000}, 40), 1'b1};
    r2      = {2'b00, 6'h3F, CID, crc7_calc({8'h0, CID}, 120), 1'b1};
    send_cmd(16'h0219, 32'h0, tx_cmd2, -1, -1, ab);
    drive_resp(r2, 136, 2);
    resp_exp = {8'h00, CID};
    wait_done(2, 5'b10000, resp_exp, 1'b0);

    // 48-bit response after a 136-bit one keeps resp[127:32]
    send_cmd(16'h081A, 32'h0000_01AA, TX_CMD8, -1, -1, ab);
    drive_resp({88'h0, 48'h08_0000_01AA_13}, 48, 0);
    resp_exp = {resp_exp[127:32], 32'h0000_01AA};
    wait_done(2, 5'b10000, resp_exp, 1'b0);

    // Reset in the middle of SEND, then a clean command
    send_cmd(16'h081A, 32'h0000_01AA, TX_CMD8, -1, 20, ab);
    check("rst_aborted", 128'(ab), 128'd1);
    send_cmd(16'h0000, 32'h0, 48'h40_0000_0000_95, -1, -1, ab);
    wait_done(0, 5'b10000, 128'd0, 1'b0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
